// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and small op-decoding helpers.
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10
   } state_t;

   function automatic logic isDivOp(input logic [1:0] opCode);
      return opCode[1];
   endfunction

   function automatic logic isSignedOp(input logic [1:0] opCode);
      return ~opCode[0];
   endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide,
// STEPS iterations per step pulse. After WIDTH iterations {accHi,accLo} holds
// the product, or accHi = remainder and accLo = quotient.
module muldiv_iter_core #(
   parameter int WIDTH = 32,
   parameter int STEPS = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             isDiv,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   output logic [WIDTH-1:0] accHi,
   output logic [WIDTH-1:0] accLo
);

   logic [WIDTH-1:0] accHi_r, accLo_r, opB_r;
   logic             isDiv_r;
   logic [WIDTH-1:0] hiNext_s, loNext_s;
   logic [WIDTH:0]   sum_s, rem_s, diff_s;

   // Unrolled iteration network for one clock worth of steps
   always_comb begin
      hiNext_s = accHi_r;
      loNext_s = accLo_r;
      sum_s    = {(WIDTH+1){1'b0}};
      rem_s    = {(WIDTH+1){1'b0}};
      diff_s   = {(WIDTH+1){1'b0}};
      for (int s = 0; s < STEPS; s++) begin
         if (isDiv_r) begin
            rem_s  = {hiNext_s, loNext_s[WIDTH-1]};
            diff_s = rem_s - {1'b0, opB_r};
            if (!diff_s[WIDTH]) begin
               hiNext_s = diff_s[WIDTH-1:0];
               loNext_s = {loNext_s[WIDTH-2:0], 1'b1};
            end else begin
               hiNext_s = rem_s[WIDTH-1:0];
               loNext_s = {loNext_s[WIDTH-2:0], 1'b0};
            end
         end else begin
            if (loNext_s[0]) begin
               sum_s = {1'b0, hiNext_s} + {1'b0, opB_r};
            end else begin
               sum_s = {1'b0, hiNext_s};
            end
            loNext_s = {sum_s[0], loNext_s[WIDTH-1:1]};
            hiNext_s = sum_s[WIDTH:1];
         end
      end
   end

   // Accumulator and operand registers
   always_ff @(posedge clock) begin
      if (reset) begin
         accHi_r <= {WIDTH{1'b0}};
         accLo_r <= {WIDTH{1'b0}};
         opB_r   <= {WIDTH{1'b0}};
         isDiv_r <= 1'b0;
      end else if (load) begin
         accHi_r <= {WIDTH{1'b0}};
         accLo_r <= opA;
         opB_r   <= opB;
         isDiv_r <= isDiv;
      end else if (step) begin
         accHi_r <= hiNext_s;
         accLo_r <= loNext_s;
      end
   end

   assign accHi = accHi_r;
   assign accLo = accLo_r;

endmodule

// File: rtl/muldiv_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU unit owning the Hi/Lo registers, with a
// start/busy/done handshake, abort and a divide-by-zero pulse.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH           = 32,
   parameter int STEPS_PER_CYCLE = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             divby0,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int N  = WIDTH / STEPS_PER_CYCLE;
   localparam int CW = $clog2(N) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

   state_t             state_r, nextState_s;
   logic [CW-1:0]      cnt_r;
   logic [1:0]         op_r;
   logic               negRes_r, negRem_r, busy_r, done_r, divby0_r;
   logic [WIDTH-1:0]   hi_r, lo_r;
   logic               accept_s, zeroDiv_s, load_s, step_s, fixWrite_s, aNeg_s, bNeg_s;
   logic [WIDTH-1:0]   magA_s, magB_s, coreHi_s, coreLo_s, quo_s, rem_s;
   logic [2*WIDTH-1:0] prod_s;

   // Acceptance decode and operand magnitudes for signed ops
   always_comb begin
      accept_s  = start & ~abort & (state_r == ST_IDLE);
      zeroDiv_s = accept_s & isDivOp(op) & (src_b == {WIDTH{1'b0}});
      aNeg_s    = isSignedOp(op) & src_a[WIDTH-1];
      bNeg_s    = isSignedOp(op) & src_b[WIDTH-1];
      magA_s    = aNeg_s ? ({WIDTH{1'b0}} - src_a) : src_a;
      magB_s    = bNeg_s ? ({WIDTH{1'b0}} - src_b) : src_b;
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= nextState_s;
      end
   end

   // Next-state and datapath control
   always_comb begin
      nextState_s = state_r;
      load_s      = 1'b0;
      step_s      = 1'b0;
      fixWrite_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s && !zeroDiv_s) begin
               nextState_s = ST_CALC;
               load_s      = 1'b1;
            end else begin
               nextState_s = ST_IDLE;
            end
         end
         ST_CALC: begin
            if (abort) begin
               nextState_s = ST_IDLE;
            end else begin
               step_s      = 1'b1;
               nextState_s = (cnt_r == CNT_ZERO) ? ST_FIX : ST_CALC;
            end
         end
         ST_FIX: begin
            nextState_s = ST_IDLE;
            fixWrite_s  = ~abort;
         end
         default: begin
            nextState_s = ST_IDLE;
         end
      endcase
   end

   muldiv_iter_core #(
      .WIDTH (WIDTH),
      .STEPS (STEPS_PER_CYCLE)
   ) u_core (
      .clock (clock),
      .reset (reset),
      .load  (load_s),
      .step  (step_s),
      .isDiv (isDivOp(op)),
      .opA   (magA_s),
      .opB   (magB_s),
      .accHi (coreHi_s),
      .accLo (coreLo_s)
   );

   // Sign correction; MIN / -1 falls out naturally as MIN with zero remainder
   always_comb begin
      prod_s = {coreHi_s, coreLo_s};
      if (negRes_r) begin
         prod_s = {(2*WIDTH){1'b0}} - prod_s;
         quo_s  = {WIDTH{1'b0}} - coreLo_s;
      end else begin
         quo_s  = coreLo_s;
      end
      if (negRem_r) begin
         rem_s = {WIDTH{1'b0}} - coreHi_s;
      end else begin
         rem_s = coreHi_s;
      end
   end

   // Counter, captured op/sign info, Hi/Lo and handshake flags
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_r    <= CNT_ZERO;
         op_r     <= OP_MULT;
         negRes_r <= 1'b0;
         negRem_r <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         divby0_r <= 1'b0;
         hi_r     <= {WIDTH{1'b0}};
         lo_r     <= {WIDTH{1'b0}};
      end else begin
         busy_r   <= (nextState_s != ST_IDLE);
         done_r   <= fixWrite_s | zeroDiv_s;
         divby0_r <= zeroDiv_s;
         if (load_s) begin
            cnt_r    <= CNT_LAST;
            op_r     <= op;
            negRes_r <= aNeg_s ^ bNeg_s;
            negRem_r <= aNeg_s;
         end else if (step_s && cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
         end
         if (fixWrite_s) begin
            if (isDivOp(op_r)) begin
               hi_r <= rem_s;
               lo_r <= quo_s;
            end else begin
               hi_r <= prod_s[2*WIDTH-1:WIDTH];
               lo_r <= prod_s[WIDTH-1:0];
            end
         end
      end
   end

   assign busy   = busy_r;
   assign done   = done_r;
   assign divby0 = divby0_r;
   assign hi     = hi_r;
   assign lo     = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: one instance with 1 step/cycle, one with 4.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic startS = 1'b0, abortS = 1'b0, startF = 1'b0, abortF = 1'b0;
   logic [1:0] opS = 2'b00, opF = 2'b00;
   logic [31:0] aS = 32'h0, bS = 32'h0, aF = 32'h0, bF = 32'h0;
   logic busyS, doneS, div0S, busyF, doneF, div0F;
   logic [31:0] hiS, loS, hiF, loF;
   int errors = 0;
   int checks = 0;

   int nDone, dc0, dc1, busyCnt, firstBusy, lastBusy, div0Cnt;
   logic busyAt, doneAt;
   logic [31:0] hi0, lo0, hi1, lo1, hiAt, loAt;

   always #5 clock = ~clock;

   muldiv_unit #(.WIDTH(32), .STEPS_PER_CYCLE(1)) dutS (
      .clock(clock), .reset(reset), .start(startS), .op(opS), .src_a(aS), .src_b(bS),
      .abort(abortS), .busy(busyS), .done(doneS), .divby0(div0S), .hi(hiS), .lo(loS));

   muldiv_unit #(.WIDTH(32), .STEPS_PER_CYCLE(4)) dutF (
      .clock(clock), .reset(reset), .start(startF), .op(opF), .src_a(aF), .src_b(bF),
      .abort(abortF), .busy(busyF), .done(doneF), .divby0(div0F), .hi(hiF), .lo(loF));

   task automatic clr();
      startS = 1'b0; abortS = 1'b0; startF = 1'b0; abortF = 1'b0; reset = 1'b0;
   endtask

   task automatic drive(input bit fast, input logic st, input logic ab, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b);
      if (fast) begin
         startF = st; abortF = ab; opF = o; aF = a; bF = b;
      end else begin
         startS = st; abortS = ab; opS = o; aS = a; bS = b;
      end
   endtask

   // Start op1 in cycle 0; evKind at evCyc: 1 = start op2, 2 = abort, 3 = reset.
   task automatic runSeq(input bit fast, input logic [1:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                         input int evCyc, input int evKind, input logic [1:0] o2,
                         input logic [31:0] a2, input logic [31:0] b2, input int maxCyc);
      logic bz, dn, dz;
      logic [31:0] h, l;
      nDone = 0; dc0 = -1; dc1 = -1; busyCnt = 0; firstBusy = -1; lastBusy = -1; div0Cnt = 0;
      busyAt = 1'bx; doneAt = 1'bx; hiAt = 32'hx; loAt = 32'hx;
      hi0 = 32'hx; lo0 = 32'hx; hi1 = 32'hx; lo1 = 32'hx;
      @(negedge clock);
      clr();
      drive(fast, 1'b1, 1'b0, o1, a1, b1);
      for (int c = 1; c <= maxCyc; c++) begin
         @(negedge clock);
         clr();
         if (c == evCyc) begin
            case (evKind)
               1: drive(fast, 1'b1, 1'b0, o2, a2, b2);
               2: drive(fast, 1'b0, 1'b1, o2, a2, b2);
               3: reset = 1'b1;
               default: ;
            endcase
         end
         bz = fast ? busyF : busyS; dn = fast ? doneF : doneS; dz = fast ? div0F : div0S;
         h = fast ? hiF : hiS; l = fast ? loF : loS;
         if (bz) begin
            busyCnt++; lastBusy = c;
            if (firstBusy < 0) firstBusy = c;
         end
         if (dz) div0Cnt++;
         if (dn) begin
            if (nDone == 0) begin dc0 = c; hi0 = h; lo0 = l; end
            else if (nDone == 1) begin dc1 = c; hi1 = h; lo1 = l; end
            nDone++;
         end
         if (c == evCyc + 1) begin busyAt = bz; doneAt = dn; hiAt = h; loAt = l; end
      end
      @(negedge clock);
      clr();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      checks++; if (busyS !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busyS); end
      checks++; if (doneS !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", doneS); end
      checks++; if (div0S !== 1'b0) begin errors++; $display("FAIL reset_divby0: got %b want 0", div0S); end
      checks++; if (hiS !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hiS); end
      checks++; if (loS !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", loS); end
      clr();
   endtask

   task automatic test_mult();
      runSeq(1'b0, OP_MULT, 32'hFFFFFFFD, 32'h7, -1, 0, OP_MULT, 32'h0, 32'h0, 40);
      checks++; if (dc0 !== 34 || nDone !== 1) begin errors++; $display("FAIL mult_done_cycle: got %0d (n=%0d) want 34", dc0, nDone); end
      checks++; if (firstBusy !== 1 || lastBusy !== 33 || busyCnt !== 33) begin errors++; $display("FAIL mult_busy_window: got %0d..%0d cnt %0d want 1..33", firstBusy, lastBusy, busyCnt); end
      checks++; if (hi0 !== 32'hFFFFFFFF || lo0 !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_neg: got %h_%h want ffffffff_ffffffeb", hi0, lo0); end
      checks++; if (div0Cnt !== 0) begin errors++; $display("FAIL mult_divby0: got %0d pulses want 0", div0Cnt); end
      runSeq(1'b0, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 0, OP_MULT, 32'h0, 32'h0, 36);
      checks++; if (hi0 !== 32'hFFFFFFFE || lo0 !== 32'h00000001) begin errors++; $display("FAIL multu_max: got %h_%h want fffffffe_00000001", hi0, lo0); end
      runSeq(1'b0, OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 0, OP_MULT, 32'h0, 32'h0, 36);
      checks++; if (hi0 !== 32'h0 || lo0 !== 32'h1) begin errors++; $display("FAIL mult_m1m1: got %h_%h want 00000000_00000001", hi0, lo0); end
   endtask

   task automatic test_div();
      runSeq(1'b0, OP_DIV, 32'hFFFFFFF9, 32'h2, -1, 0, OP_MULT, 32'h0, 32'h0, 36);
      checks++; if (lo0 !== 32'hFFFFFFFD || hi0 !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg7_2: got lo=%h hi=%h want fffffffd ffffffff", lo0, hi0); end
      checks++; if (dc0 !== 34) begin errors++; $display("FAIL div_done_cycle: got %0d want 34", dc0); end
      runSeq(1'b0, OP_DIVU, 32'h7, 32'h2, -1, 0, OP_MULT, 32'h0, 32'h0, 36);
      checks++; if (lo0 !== 32'h3 || hi0 !== 32'h1) begin errors++; $display("FAIL divu_7_2: got lo=%h hi=%h want 3 1", lo0, hi0); end
      runSeq(1'b0, OP_DIV, 32'h80000000, 32'hFFFFFFFF, -1, 0, OP_MULT, 32'h0, 32'h0, 36);
      checks++; if (lo0 !== 32'h80000000 || hi0 !== 32'h0 || div0Cnt !== 0) begin errors++; $display("FAIL div_min_m1: got lo=%h hi=%h flags=%0d want 80000000 0 0", lo0, hi0, div0Cnt); end
   endtask

   task automatic test_divby0();
      runSeq(1'b0, OP_DIVU, 32'd95, 32'd10, -1, 0, OP_MULT, 32'h0, 32'h0, 36);
      checks++; if (lo0 !== 32'd9 || hi0 !== 32'd5) begin errors++; $display("FAIL divu_95_10: got lo=%h hi=%h want 9 5", lo0, hi0); end
      runSeq(1'b0, OP_DIV, 32'd123, 32'h0, -1, 0, OP_MULT, 32'h0, 32'h0, 6);
      checks++; if (dc0 !== 1 || nDone !== 1) begin errors++; $display("FAIL dz_done: got cycle %0d n=%0d want 1 1", dc0, nDone); end
      checks++; if (div0Cnt !== 1) begin errors++; $display("FAIL dz_flag: got %0d pulses want 1", div0Cnt); end
      checks++; if (busyCnt !== 0) begin errors++; $display("FAIL dz_busy: got %0d busy cycles want 0", busyCnt); end
      checks++; if (hiS !== 32'd5 || loS !== 32'd9) begin errors++; $display("FAIL dz_hilo_kept: got %h %h want 5 9", hiS, loS); end
      runSeq(1'b0, OP_MULTU, 32'd77, 32'h0, -1, 0, OP_MULT, 32'h0, 32'h0, 36);
      checks++; if (div0Cnt !== 0 || dc0 !== 34 || lo0 !== 32'h0) begin errors++; $display("FAIL mult_by0: got flags=%0d cycle=%0d lo=%h want 0 34 0", div0Cnt, dc0, lo0); end
      runSeq(1'b0, OP_DIVU, 32'd95, 32'd10, -1, 0, OP_MULT, 32'h0, 32'h0, 36);
   endtask

   task automatic test_abort();
      runSeq(1'b0, OP_MULT, 32'd3, 32'd4, 10, 2, OP_MULT, 32'd3, 32'd4, 45);
      checks++; if (busyAt !== 1'b0 || lastBusy !== 10) begin errors++; $display("FAIL abort_busy: got busy=%b last=%0d want 0 10", busyAt, lastBusy); end
      checks++; if (nDone !== 0) begin errors++; $display("FAIL abort_no_done: got %0d dones want 0", nDone); end
      checks++; if (hiS !== 32'd5 || loS !== 32'd9) begin errors++; $display("FAIL abort_hilo: got %h %h want 5 9", hiS, loS); end
      @(negedge clock);
      drive(1'b0, 1'b1, 1'b1, OP_DIV, 32'd1, 32'h0);
      @(negedge clock);
      clr();
      checks++; if (busyS !== 1'b0 || doneS !== 1'b0 || div0S !== 1'b0) begin errors++; $display("FAIL abort_idle_block: got busy=%b done=%b dz=%b want 0 0 0", busyS, doneS, div0S); end
   endtask

   task automatic test_ignore_busy();
      runSeq(1'b0, OP_MULT, 32'd3, 32'd4, 5, 1, OP_DIVU, 32'd100, 32'd7, 80);
      checks++; if (nDone !== 1 || dc0 !== 34) begin errors++; $display("FAIL ignore_done: got n=%0d cycle=%0d want 1 34", nDone, dc0); end
      checks++; if (lo0 !== 32'd12 || hi0 !== 32'd0) begin errors++; $display("FAIL ignore_result: got lo=%h hi=%h want c 0", lo0, hi0); end
   endtask

   task automatic test_reset_mid();
      runSeq(1'b0, OP_DIVU, 32'd100, 32'd7, 5, 3, OP_DIVU, 32'd100, 32'd7, 40);
      checks++; if (busyAt !== 1'b0 || doneAt !== 1'b0 || hiAt !== 32'h0 || loAt !== 32'h0) begin errors++; $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h want all 0", busyAt, doneAt, hiAt, loAt); end
      checks++; if (nDone !== 0) begin errors++; $display("FAIL reset_mid_no_done: got %0d want 0", nDone); end
   endtask

   task automatic test_back_to_back();
      runSeq(1'b0, OP_MULT, 32'd3, 32'd4, 34, 1, OP_DIVU, 32'd100, 32'd7, 75);
      checks++; if (dc0 !== 34 || lo0 !== 32'd12) begin errors++; $display("FAIL b2b_first: got cycle=%0d lo=%h want 34 c", dc0, lo0); end
      checks++; if (dc1 !== 68 || lo1 !== 32'd14 || hi1 !== 32'd2) begin errors++; $display("FAIL b2b_second: got cycle=%0d lo=%h hi=%h want 68 e 2", dc1, lo1, hi1); end
      runSeq(1'b1, OP_MULT, 32'd3, 32'd4, 10, 1, OP_DIVU, 32'd100, 32'd7, 30);
      checks++; if (dc0 !== 10 || lo0 !== 32'd12) begin errors++; $display("FAIL b2b4_first: got cycle=%0d lo=%h want 10 c", dc0, lo0); end
      checks++; if (dc1 !== 20 || lo1 !== 32'd14 || hi1 !== 32'd2) begin errors++; $display("FAIL b2b4_second: got cycle=%0d lo=%h hi=%h want 20 e 2", dc1, lo1, hi1); end
      runSeq(1'b1, OP_DIV, 32'hFFFFFFF9, 32'h2, -1, 0, OP_MULT, 32'h0, 32'h0, 14);
      checks++; if (dc0 !== 10 || lo0 !== 32'hFFFFFFFD || hi0 !== 32'hFFFFFFFF) begin errors++; $display("FAIL div4_neg: got cycle=%0d lo=%h hi=%h want 10 fffffffd ffffffff", dc0, lo0, hi0); end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_divby0();
      test_abort();
      test_ignore_busy();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
